// File: rtl/video_scanout.sv
// Raster timing generator: counters drive the video RAM address; sync/de/pixel are delayed RAM_LAT+1 cycles to line up with rdata.
// Optional feature macro VIDEO_SCANOUT_TEST_PATTERN_EN adds the test_pattern input (8x8 checkerboard in place of rdata).
module video_scanout #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   BPP       = 1,
  parameter int   RAM_LAT   = 1,
  parameter int   ROW_W     = 16,
  parameter int   COL_W     = 16
) (
  input  logic                   pixelclk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic [ROW_W+COL_W-1:0] raddr,
  input  logic [BPP-1:0]         rdata,
`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
  input  logic                   test_pattern,
`endif
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [BPP-1:0]         pixel,
  output logic                   frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS_C  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SE_C  = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS_C  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SE_C  = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic pat_en;
    logic pat_bit;
  } stage_t;

  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic [VW-1:0]          vcnt_q, vcnt_d;
  logic [ROW_W-1:0]       row;
  logic [COL_W-1:0]       col;
  logic [ROW_W+COL_W-1:0] cur_addr, last_q;
  stage_t                 s0, tail;
  stage_t [RAM_LAT-1:0]   pipe_q;
  logic                   hsync_q, vsync_q, de_q, fs_q;
  logic [BPP-1:0]         pixel_q, pixel_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!enable) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  assign row      = ROW_W'(vcnt_q);
  assign col      = COL_W'(hcnt_q);
  assign cur_addr = {row, col};

  // Stage-0 view of the raster; everything is forced idle while disabled.
  always_comb begin
    s0    = '0;
    s0.de = enable && (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    s0.hs = enable && (hcnt_q >= H_SS_C) && (hcnt_q < H_SE_C);
    s0.vs = enable && (vcnt_q >= V_SS_C) && (vcnt_q < V_SE_C);
    s0.fs = enable && (hcnt_q == '0) && (vcnt_q == '0);
`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
    s0.pat_en  = test_pattern;
    s0.pat_bit = row[3] ^ col[3];
`endif
  end

  assign raddr = s0.de ? cur_addr : last_q;
  assign tail  = pipe_q[RAM_LAT-1];

  always_comb begin
    pixel_d = '0;
    if (tail.de) begin
      pixel_d = rdata;
`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
      if (tail.pat_en) pixel_d = {BPP{tail.pat_bit}};
`endif
    end
  end

  // RAM_LAT stages match the RAM; the output register adds the final cycle.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      last_q  <= '0;
      pipe_q  <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      pixel_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (s0.de) last_q <= cur_addr;
      pipe_q[0] <= s0;
      for (int i = 1; i < RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      hsync_q <= tail.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= tail.vs ? VSYNC_POL : ~VSYNC_POL;
      de_q    <= tail.de;
      fs_q    <= tail.fs;
      pixel_q <= pixel_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel       = pixel_q;
  assign frame_start = fs_q;

endmodule

// File: doc/video_scanout.md
VIDEO_SCANOUT -- requirements
Module: video_scanout

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FRONT/H_SYNC/H_BACK, 16/96/48; horizontal porch and sync widths in pixels, each >=1.
REQ-003 Parameters V_ACTIVE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33; same in lines, each >=1.
REQ-004 Parameters HSYNC_POL/VSYNC_POL, 1/0; asserted sync level.
REQ-005 Parameters BPP, 1; bits per pixel. RAM_LAT, 1; video RAM read latency in cycles, >=1.
REQ-006 Parameters ROW_W/COL_W, 16/16; row and column field widths in raddr.
REQ-007 pixelclk  in  1  pixel clock; all logic on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 enable  in  1  scanning runs while high.
REQ-010 raddr  out  ROW_W+COL_W  video RAM read address {row, col}.
REQ-011 rdata  in  BPP  video RAM data, valid RAM_LAT cycles after raddr.
REQ-012 hsync / vsync  out  1 each  sync outputs at the polarity set by the parameters.
REQ-013 de  out  1  data enable (active region).
REQ-014 pixel  out  BPP  pixel data; zero when de low.
REQ-015 frame_start  out  1  one-cycle pulse coincident with pixel (0,0) on the outputs.
REQ-016 test_pattern  in  1  present only with TEST_PATTERN_EN.

Function
REQ-017 hcnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H params); wraps to 0; vcnt increments at the hcnt wrap and counts 0..V_TOTAL-1, then wraps.
REQ-018 Line order: active, front, sync, back; same order vertically.
REQ-019 Stage-0 active = hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-020 Stage-0 hsync asserted for hcnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC); vsync likewise on vcnt, changing only at the hcnt wrap.
REQ-021 raddr is combinational from the counters: {vcnt[ROW_W-1:0], hcnt[COL_W-1:0]}; it holds the last active value outside the active region.
REQ-022 hsync, vsync, de, pixel and frame_start are registered and delayed by exactly RAM_LAT+1 cycles from the stage-0 counter state.
REQ-023 pixel = rdata when the delayed active is high; otherwise 0.
REQ-024 When enable is low: counters hold at 0 and stage-0 signals are forced inactive. The pipeline keeps clocking, so the outputs reach their inactive levels RAM_LAT+1 cycles later.
REQ-025 On an enable rise, scanning starts at (0,0); frame_start fires RAM_LAT+1 cycles later.
REQ-026 Counter widths are sized by $clog2 of the totals; there is no overflow past the totals.

Reset
REQ-027 On rst_n low, immediately and asynchronously: counters 0; pipeline cleared; hsync = ~HSYNC_POL; vsync = ~VSYNC_POL; de = 0; pixel = 0; frame_start = 0.
REQ-028 Reset deasserted with enable high: the first frame begins at (0,0) on the next edge.
REQ-029 Reset mid-frame aborts the frame; no partial-frame output follows.

Configuration
REQ-030 Macro VIDEO_SCANOUT_TEST_PATTERN_EN defined: the test_pattern port exists.
- When test_pattern is high, the active pixel is all-ones if (row[3]^col[3]) else 0, with the same pipeline delay.
- rdata is ignored while test_pattern is high.
REQ-031 Macro undefined: the test_pattern port and the pattern logic are absent, and pixel is always from rdata.

Verification
Bench parameters for REQ-032 to REQ-036: H 4/1/2/1, V 3/1/1/1, RAM_LAT=2, POL 1/0, BPP=1. The bench RAM returns col[0].
REQ-032 Reset, then enable high:
- frame_start pulses at cycle 3 after release, with de=1 and pixel=0.
- de is high for 4 of every 8 cycles; pixel pattern 0,1,0,1.
REQ-033 Free run for 2 frames:
- hsync is high 2 cycles per 8, starting 5 cycles after de rises.
- vsync is low for exactly 8 cycles per 48-cycle frame.
- frame_start period is 48.
REQ-034 Drop enable at hcnt=2:
- outputs go inactive 3 cycles later.
- re-enable: frame_start occurs 3 cycles after the rise.
REQ-035 Assert rst_n low mid-line: outputs reach their reset values in the same cycle with no clock edge; raddr = 0.
REQ-036 TEST_PATTERN_EN defined, test_pattern=1, default 640x480: pixel toggles every 8 columns, with a phase flip every 8 rows.
